// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding, sync marker default and
// instruction word width.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CKSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         INSN_W        = 16;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler: latches the high byte and forms {hi,lo}.
// With IMEM_LOADER_CKSUM_EN it also keeps a running XOR of count and data bytes.
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_hi_we,
`ifdef IMEM_LOADER_CKSUM_EN
    input  logic              i_clr,
    input  logic              i_acc,
    output logic [7:0]        o_xor,
`endif
    input  logic [7:0]        i_byte,
    output logic [INSN_W-1:0] o_word
);

    logic [7:0] r_hi;

    // Hold the high byte until its low partner arrives.
    always_ff @(posedge clk) begin
        if (reset)
            r_hi <= '0;
        else if (i_hi_we)
            r_hi <= i_byte;
    end

    assign o_word = {r_hi, i_byte};

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] r_xor;

    // Running XOR of the count byte and every data byte of the frame.
    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_xor <= '0;
        else if (i_acc)
            r_xor <= r_xor ^ i_byte;
    end

    assign o_xor = r_xor;
`endif

endmodule

// File: rtl/imem_loader.sv
// Instruction RAM loader: parses SYNC,N,words[,cksum] frames into RAM writes
// and holds the CPU while loading. Optional checksum: IMEM_LOADER_CKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter int         DEPTH     = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [INSN_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);
`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t S_TAIL = S_CKSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [7:0]          r_cnt;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [INSN_W-1:0]   r_wr_data;
    logic                r_hold;
    logic                r_error;
    logic                w_xfer;
    logic                w_sync;
    logic                w_cnt_we;
    logic                w_hi_we;
    logic                w_wr;
    logic                w_last;
    logic [INSN_W-1:0]   w_word;

    assign in_ready = ~reset & (r_state != S_DONE);
    assign w_xfer   = in_valid & in_ready;
    assign w_last   = ({{(8-ADDR_W){1'b0}}, r_ptr} + 8'd1) == r_cnt;

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] w_xor;
    logic       w_acc;

    assign w_acc = w_xfer &
        ((r_state == S_COUNT) | (r_state == S_HI) | (r_state == S_LO));
`endif

    loader_word_asm u_asm (
        .clk     (clk),
        .reset   (reset),
        .i_hi_we (w_hi_we),
`ifdef IMEM_LOADER_CKSUM_EN
        .i_clr   (w_sync),
        .i_acc   (w_acc),
        .o_xor   (w_xor),
`endif
        .i_byte  (in_data),
        .o_word  (w_word)
    );

    // Next-state decode and per-byte action strobes.
    always_comb begin
        w_next   = r_state;
        w_sync   = 1'b0;
        w_cnt_we = 1'b0;
        w_hi_we  = 1'b0;
        w_wr     = 1'b0;
        unique case (r_state)
            S_IDLE, S_ERR: begin
                w_next = S_IDLE;
                if (w_xfer && in_data == SYNC_BYTE) begin
                    w_next = S_COUNT;
                    w_sync = 1'b1;
                end
            end
            S_COUNT: if (w_xfer) begin
                w_cnt_we = 1'b1;
                if (in_data > DEPTH_B)
                    w_next = S_ERR;
                else if (in_data == 8'd0)
                    w_next = S_TAIL;
                else
                    w_next = S_HI;
            end
            S_HI: if (w_xfer) begin
                w_hi_we = 1'b1;
                w_next  = S_LO;
            end
            S_LO: if (w_xfer) begin
                w_wr   = 1'b1;
                w_next = w_last ? S_TAIL : S_HI;
            end
            S_CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
                if (w_xfer)
                    w_next = (in_data == w_xor) ? S_DONE : S_ERR;
`else
                w_next = S_IDLE;
`endif
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, word pointer, write port and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_hold    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_wr;
            if (w_sync) begin
                r_ptr   <= '0;
                r_hold  <= 1'b1;
                r_error <= 1'b0;
            end
            if (w_cnt_we)
                r_cnt <= in_data;
            if (w_wr) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_word;
                r_ptr     <= r_ptr + ADDR_W'(1);
            end
            if (w_next == S_DONE)
                r_hold <= 1'b0;
            if (w_next == S_ERR)
                r_error <= 1'b1;
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_hold;
    assign done     = (r_state == S_DONE);
    assign error    = r_error;

endmodule
